// File: rtl/core_pkg.sv
// Types and constants shared by the RV32 front-end.
// Fetch FSM encoding and the {pc, instr} entry carried from fetch to decode.
package core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO between fetch and decode; the head is read combinationally.
// A synchronous clear overrides push and pop in the same cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  T              i_push_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output T              o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!w_full || w_do_pop);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem[gi] <= '0;
        end else if (!i_clear && w_do_push && (r_wr_ptr == PW'(gi))) begin
          r_mem[gi] <= i_push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, {pc, instr} FIFO towards decode,
// and redirect handling that flushes the FIFO and drops a stale response.
module fetch_stage
  import core_pkg::*;
#(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pending_pc;

  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_room_idle;
  logic            w_room_chain;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;

  // Credit is judged on the current occupancy only; a pop this cycle does not count.
  assign w_room_idle  = int'(w_count) < DEPTH;
  assign w_room_chain = (int'(w_count) + 1) < DEPTH;

  assign w_req_valid = !rst && !redirect_valid &&
                       (((r_state == FETCH) && w_room_idle) ||
                        ((r_state == WAIT) && imem_resp_valid && w_room_chain));
  assign w_fire      = w_req_valid && imem_req_ready;
  assign w_push      = (r_state == WAIT) && imem_resp_valid && !redirect_valid;
  assign w_pop       = out_valid && out_ready && !redirect_valid;

  assign w_redirect_pc      = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_push_entry.pc    = r_pending_pc;
  assign w_push_entry.instr = imem_resp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      // A request still in flight must be drained before fetching again.
      r_state    <= (((r_state == WAIT) || (r_state == DROP)) && !imem_resp_valid)
                    ? DROP : FETCH;
    end else begin
      if (w_fire) begin
        r_pending_pc <= r_fetch_pc;
        r_fetch_pc   <= r_fetch_pc + XLEN'(INSTR_BYTES);
        r_state      <= WAIT;
      end else begin
        case (r_state)
          WAIT:    if (imem_resp_valid) r_state <= FETCH;
          DROP:    if (imem_resp_valid) r_state <= FETCH;
          default: r_state <= FETCH;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign out_valid      = (w_count != '0);
  assign out_pc         = w_head.pc;
  assign out_instr      = w_head.instr;

  resp_in_fetch : assert property (@(posedge clk) disable iff (rst)
    !((r_state == FETCH) && imem_resp_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an imem responder, a scoreboard of expected
// {pc, instr} pairs, and a negedge monitor checking the request and decode sides.
module tb_fetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  fetch_stage #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          consumed = 0;
  int          lat_max = 0;
  logic [31:0] exp_addr = RESET_PC;
  bit          mem_pending = 0;
  bit          mem_stale = 0;
  logic [31:0] mem_addr = '0;
  int          mem_due = 0;
  bit          prev_stalled = 0;

  // Contents of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  // Memory responder: answers the single accepted request once its latency expires.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mem_pending && (cyc >= mem_due)) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(mem_addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  // Monitor: check what is visible this cycle, then apply what the next edge does.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        exp_q.delete();
        exp_addr     = RESET_PC;
        mem_pending  = 0;
        mem_stale    = 0;
        prev_stalled = 0;
      end else begin
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (out_valid && exp_q.size() > 0) begin
          check("out_pc", out_pc, exp_q[0].pc);
          check("out_instr", out_instr, exp_q[0].instr);
        end
        if (redirect_valid) begin
          check("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
        end else if (prev_stalled) begin
          check("req_hold", 32'(imem_req_valid), 32'd1);
        end
        if (imem_req_valid) begin
          check("req_addr", imem_req_addr, exp_addr);
        end
        check("req_overissue",
              32'(imem_req_valid && ((mem_pending && !imem_resp_valid) || exp_q.size() >= DEPTH)),
              32'd0);

        if (out_valid && out_ready && !redirect_valid && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          consumed++;
        end
        if (imem_resp_valid) begin
          if (!redirect_valid && !mem_stale) begin
            exp_q.push_back('{pc: mem_addr, instr: instr_of(mem_addr)});
          end
          mem_pending = 0;
          mem_stale   = 0;
        end
        prev_stalled = imem_req_valid && !imem_req_ready;
        if (imem_req_valid && imem_req_ready) begin
          mem_pending = 1;
          mem_stale   = 0;
          mem_addr    = imem_req_addr;
          mem_due     = cyc + 1 + int'($urandom_range(0, lat_max));
          exp_addr    = exp_addr + 32'd4;
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_addr = {redirect_pc[31:2], 2'b00};
          if (mem_pending) mem_stale = 1;
        end
      end
    end
  end

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_phase(input int n, input int p_req, input int p_out, input int p_redir,
                           input int lat);
    lat_max = lat;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      imem_req_ready = ($urandom_range(0, 99) < p_req);
      out_ready      = ($urandom_range(0, 99) < p_out);
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      redirect_pc    = pick_target();
    end
  endtask

  task automatic redirect_once(input logic [31:0] target);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);

    run_phase(30, 100, 100, 0, 0);       // streaming, 1-cycle latency
    run_phase(15, 100, 0, 0, 0);         // decode backpressure fills the FIFO
    run_phase(10, 100, 100, 0, 0);
    redirect_once(32'h0000_0103);        // misaligned target gets aligned
    run_phase(20, 100, 100, 0, 2);
    run_phase(20, 0, 100, 0, 0);         // request stalled by memory
    redirect_once(32'hFFFF_FFFC);        // address wraps to zero
    run_phase(20, 100, 100, 0, 0);
    run_phase(300, 100, 100, 10, 3);
    run_phase(300, 40, 60, 5, 3);
    for (int k = 0; k < 8; k++) begin
      run_phase(150, int'($urandom_range(20, 100)), int'($urandom_range(10, 100)),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 4)));
    end
    run_phase(40, 100, 100, 0, 0);
    @(negedge clk);
    check("liveness_consumed", 32'(consumed > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
